// File: rtl/lc4_rob_param_pkg.sv
// rtl/lc4_rob_param_pkg.sv - shared widths, entry status encoding and index-width helper for the reorder buffer
package lc4_rob_param_pkg;

  localparam int ROB_DEPTH_DEF  = 8;
  localparam int ROB_DATA_W_DEF = 16;
  localparam int ROB_PR_W_DEF   = 4;

  // Lifecycle of one entry as seen by the commit stage.
  typedef enum logic [1:0] {
    ROB_FREE   = 2'b00,
    ROB_WAIT   = 2'b01,
    ROB_ISSUED = 2'b10,
    ROB_DONE   = 2'b11
  } rob_status_e;

  function automatic int rob_idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic rob_status_e rob_status(input logic valid, input logic issued, input logic done);
    if (!valid)     return ROB_FREE;
    else if (done)  return ROB_DONE;
    else if (issued) return ROB_ISSUED;
    else            return ROB_WAIT;
  endfunction

endpackage

// File: rtl/lc4_rob_ram_2r1w.sv
// rtl/lc4_rob_ram_2r1w.sv - DEPTH-entry register array, one synchronous write port, two async read ports
module lc4_rob_ram_2r1w #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr_a,
  output logic [W-1:0]     rdata_a,
  input  logic [IDX_W-1:0] raddr_b,
  output logic [W-1:0]     rdata_b
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lc4_rob_param.sv
// rtl/lc4_rob_param.sv - parametrised reorder buffer with occupancy count and random read port
// Selective squash of younger entries is built only when LC4_ROB_SQUASH_EN is defined.
module lc4_rob_param
  import lc4_rob_param_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH_DEF,
  parameter int IDX_W  = rob_idx_w(DEPTH),
  parameter int DATA_W = ROB_DATA_W_DEF,
  parameter int PR_W   = ROB_PR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gwe,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic [DATA_W-1:0] enq_insn,
  input  logic [DATA_W-1:0] enq_pc,
  input  logic [DATA_W-1:0] enq_pc_pred,
  input  logic [PR_W-1:0]   enq_pr1sel,
  input  logic [PR_W-1:0]   enq_pr2sel,
  input  logic [PR_W-1:0]   enq_prdsel,
  input  logic [PR_W-1:0]   enq_pprdsel,
  output logic              enq_ready,
  output logic [IDX_W-1:0]  enq_index,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_index,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_index,
  input  logic [DATA_W-1:0] wb_pc_redirect,
  input  logic [DATA_W-1:0] wb_rddata,
  input  logic [IDX_W-1:0]  rs_index,
  output logic [DATA_W-1:0] rs_insn,
  output logic [DATA_W-1:0] rs_pc,
  output logic [DATA_W-1:0] rs_pc_pred,
  output logic [PR_W-1:0]   rs_pr1sel,
  output logic [PR_W-1:0]   rs_pr2sel,
  output logic [PR_W-1:0]   rs_prdsel,
  input  logic              deq,
  output logic              cm_ready,
  output logic [IDX_W-1:0]  cm_index,
  output logic [DATA_W-1:0] cm_insn,
  output logic [DATA_W-1:0] cm_pc,
  output logic [DATA_W-1:0] cm_pc_pred,
  output logic [DATA_W-1:0] cm_pc_redirect,
  output logic [DATA_W-1:0] cm_rddata,
  output logic [PR_W-1:0]   cm_prdsel,
  output logic [PR_W-1:0]   cm_pprdsel,
  input  logic              squash_valid,
  input  logic [IDX_W-1:0]  squash_index,
  output logic [DEPTH-1:0]  valid_vec,
  output logic [DEPTH-1:0]  issued_vec,
  output logic [DEPTH-1:0]  done_vec,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam int DSP_W = 3*DATA_W + 4*PR_W;
  localparam int WBK_W = 2*DATA_W;
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] head_q, head_n, tail_q, tail_n, sq_off;
  logic [IDX_W:0]   count_q, count_n;
  logic [DEPTH-1:0] valid_q, valid_n, issued_q, issued_n, done_q, done_n, kill;
  logic             enq_acc, iss_acc, wbk_acc, ret_acc, sq_acc;

  logic [DSP_W-1:0]    dsp_cm, dsp_rs;
  logic [WBK_W-1:0]    wbk_cm, wbk_rs_unused;
  logic [2*PR_W-1:0]   cm_src_unused;
  logic [PR_W-1:0]     rs_pprd_unused;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign cm_ready  = valid_q[head_q] & done_q[head_q];

`ifdef LC4_ROB_SQUASH_EN
  assign sq_acc = squash_valid & valid_q[squash_index] & ~flush;
  assign sq_off = squash_index - head_q;

  // Age is the distance from head; anything older-or-equal to squash_index survives.
  always_comb begin
    kill = '0;
    if (sq_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && ((IDX_W'(i) - head_q) > sq_off)) kill[i] = 1'b1;
      end
    end
  end
`else
  wire unused_squash = ^{squash_valid, squash_index};
  assign sq_acc = 1'b0;
  assign sq_off = '0;
  assign kill   = '0;
`endif

  assign enq_acc = enq_valid & ~full & ~flush & ~sq_acc;
  assign iss_acc = issue_valid & valid_q[issue_index] & ~issued_q[issue_index] & ~flush & ~kill[issue_index];
  assign wbk_acc = wb_valid & valid_q[wb_index] & ~done_q[wb_index] & ~flush & ~kill[wb_index];
  assign ret_acc = deq & cm_ready & ~flush;

  always_comb begin
    head_n   = head_q;
    tail_n   = tail_q;
    count_n  = count_q + (IDX_W+1)'(enq_acc) - (IDX_W+1)'(ret_acc);
    valid_n  = valid_q;
    issued_n = issued_q;
    done_n   = done_q;
    if (enq_acc) begin
      valid_n[tail_q]  = 1'b1;
      issued_n[tail_q] = 1'b0;
      done_n[tail_q]   = 1'b0;
      tail_n           = tail_q + 1'b1;
    end
    if (iss_acc) issued_n[issue_index] = 1'b1;
    if (wbk_acc) done_n[wb_index] = 1'b1;
    if (ret_acc) begin
      valid_n[head_q] = 1'b0;
      head_n          = head_q + 1'b1;
    end
    if (sq_acc) begin
      valid_n  = valid_n & ~kill;
      issued_n = issued_n & ~kill;
      done_n   = done_n & ~kill;
      tail_n   = squash_index + 1'b1;
      count_n  = {1'b0, sq_off} + (IDX_W+1)'(1) - (IDX_W+1)'(ret_acc);
    end
    if (flush) begin
      head_n   = '0;
      tail_n   = '0;
      count_n  = '0;
      valid_n  = '0;
      issued_n = '0;
      done_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
    end else if (gwe) begin
      head_q   <= head_n;
      tail_q   <= tail_n;
      count_q  <= count_n;
      valid_q  <= valid_n;
      issued_q <= issued_n;
      done_q   <= done_n;
    end
  end

  lc4_rob_ram_2r1w #(.DEPTH(DEPTH), .IDX_W(IDX_W), .W(DSP_W)) u_dsp_ram (
    .clk     (clk),
    .we      (gwe & ~rst & enq_acc),
    .waddr   (tail_q),
    .wdata   ({enq_insn, enq_pc, enq_pc_pred, enq_pr1sel, enq_pr2sel, enq_prdsel, enq_pprdsel}),
    .raddr_a (head_q),
    .rdata_a (dsp_cm),
    .raddr_b (rs_index),
    .rdata_b (dsp_rs)
  );

  lc4_rob_ram_2r1w #(.DEPTH(DEPTH), .IDX_W(IDX_W), .W(WBK_W)) u_wbk_ram (
    .clk     (clk),
    .we      (gwe & ~rst & wbk_acc),
    .waddr   (wb_index),
    .wdata   ({wb_pc_redirect, wb_rddata}),
    .raddr_a (head_q),
    .rdata_a (wbk_cm),
    .raddr_b (rs_index),
    .rdata_b (wbk_rs_unused)
  );

  assign {cm_insn, cm_pc, cm_pc_pred, cm_src_unused, cm_prdsel, cm_pprdsel} = dsp_cm;
  assign {rs_insn, rs_pc, rs_pc_pred, rs_pr1sel, rs_pr2sel, rs_prdsel, rs_pprd_unused} = dsp_rs;
  assign {cm_pc_redirect, cm_rddata} = wbk_cm;

  assign enq_ready  = ~full;
  assign enq_index  = tail_q;
  assign cm_index   = head_q;
  assign valid_vec  = valid_q;
  assign issued_vec = issued_q;
  assign done_vec   = done_q;
  assign count      = count_q;

endmodule

// File: doc/lc4_rob_param.md
Name: lc4_rob_param

Overview:
- Parametrised reorder buffer: circular buffer of DEPTH in-flight instructions, per-entry valid/issued/done status.
- Sits between rename/dispatch and the commit stage. Accepts one dispatch, one issue mark, one writeback and one retire per cycle.
- Adds over the fixed 4-entry buffer: configurable depth, an occupancy counter, an indexed random read port for the issue logic, and optional selective squash of younger entries.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
IDX_W, 3, entry index width; must equal log2(DEPTH)
DATA_W, 16, width of insn/pc/data fields
PR_W, 4, physical register select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
gwe  in  1  global write enable; state updates only when high
flush  in  1  discard all entries
enq_valid  in  1  dispatch request
enq_insn/enq_pc/enq_pc_pred  in  DATA_W each  dispatched fields
enq_pr1sel/enq_pr2sel/enq_prdsel/enq_pprdsel  in  PR_W each  rename fields
enq_ready  out  1  ~full
enq_index  out  IDX_W  tail index the next dispatch will occupy
issue_valid  in  1  mark entry issued
issue_index  in  IDX_W  entry to mark
wb_valid  in  1  writeback; marks entry done
wb_index  in  IDX_W  entry written back
wb_pc_redirect/wb_rddata  in  DATA_W each  writeback results
rs_index  in  IDX_W  random read select
rs_insn/rs_pc/rs_pc_pred  out  DATA_W each  fields of entry rs_index
rs_pr1sel/rs_pr2sel/rs_prdsel  out  PR_W each  fields of entry rs_index
deq  in  1  retire head
cm_ready  out  1  head valid & done
cm_index  out  IDX_W  head index
cm_insn/cm_pc/cm_pc_pred/cm_pc_redirect/cm_rddata  out  DATA_W each  head fields
cm_prdsel/cm_pprdsel  out  PR_W each  head rename fields
squash_valid  in  1  selective squash (feature-gated)
squash_index  in  IDX_W  youngest surviving entry
valid_vec/issued_vec/done_vec  out  DEPTH each  per-entry status
count  out  IDX_W+1  occupancy
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Clock and reset: all state changes on rising clk. rst has highest priority and acts regardless of gwe. Otherwise there is no change while gwe=0.
- Reset values: head=0, tail=0, count=0, status vectors 0. Hence full=0, empty=1, enq_ready=1, cm_ready=0, enq_index=0, cm_index=0. Data RAM contents are don't-care.
- Accepted events:
  - enq = enq_valid & ~full & ~flush.
  - iss = issue_valid & valid[issue_index] & ~issued[issue_index] & ~flush.
  - wbk = wb_valid & valid[wb_index] & ~done[wb_index] & ~flush.
  - ret = deq & cm_ready & ~flush.
  - Requests not accepted are silently dropped.
- Enqueue: writes the fields at tail; sets valid; clears issued and done; tail = tail+1 mod DEPTH.
- Issue: sets issued[issue_index].
- Writeback: writes pc_redirect and rddata at wb_index; sets done. A writeback to the head is visible on cm_* the next cycle. Writeback does not require issued.
- Retire: clears valid at head; head = head+1 mod DEPTH.
- Count: next count = count + enq - ret. Simultaneous enq and ret while full is impossible, since enq requires ~full. Simultaneous enq and ret while count=1 leaves count=1.
- Flush: head=tail=count=0 and all vectors cleared. Flush overrides every other event in that cycle.
- Read paths: rs_* and cm_* are combinational reads of registered state, so latency is 0 from rs_index and from head.
- Wrap-around: pointers wrap at DEPTH-1 to 0. full and empty are derived only from count, never from pointer equality.
- Index rule: an index out of the valid window counts as not valid. No error is raised.

Optional Feature:
LC4_ROB_SQUASH_EN
- Defined, and squash_valid & valid[squash_index] & ~flush holds:
  - Clear valid/issued/done of every entry strictly younger than squash_index.
  - tail = squash_index+1 mod DEPTH.
  - count = ((squash_index - head) mod DEPTH) + 1, minus 1 if ret occurs that cycle.
  - enq that cycle is suppressed.
  - iss/wbk targeting a squashed entry are dropped.
- Not defined: squash_valid and squash_index are ignored. Only full flush recovers.

Decomposition:
- Shared package: rob entry status encoding, the IDX_W = log2(DEPTH) helper function, and default field widths.
- One natural sub-module: lc4_rob_ram_2r1w, a DEPTH-entry array with one write port and two async read ports (head and rs_index). It is instantiated once per field group: dispatch fields and writeback fields.

Test Plan:
- Reset, then fill DEPTH=8 with pc 0x10..0x17 → full=1, count=8, enq_ready=0; a 9th enq is dropped and tail stays 0.
- wb at idx 2, then idx 0 with rddata 0xBEEF → cm_ready=1 only after idx 0 is done; deq retires idx 0, then cm_ready=0 until idx 1 is done.
- Wrap: 12 enq/ret pairs at count=1 → head and tail wrap 7→0, count stays 1, cm_pc follows enqueue order.
- Flush in the same cycle as enq, wb and deq → next cycle count=0, empty=1, vectors 0, enq_index=0.
- With LC4_ROB_SQUASH_EN, head=6, 6 entries (6..3), squash_index=7 → tail=0, count=2, valid_vec=8'b1100_0000; a same-cycle wb to idx 1 is dropped.
- Duplicate issue or wb to a done or invalid index → no state change, count unchanged.
